// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register unit: reserved register indices,
// the stack-pointer reset value and the address-width helper.
package regfile_pkg;

  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned SP_IDX   = 2;
  localparam logic [31:0] SP_INIT  = 32'h0000_0200;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a registered population
// count of the bitmap, and per-read-port busy flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = addr_w(NUM_REGS),
  localparam int unsigned CW      = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  output logic [NUM_RD-1:0]    rs_busy,
  output logic [CW-1:0]        busy_count
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [CW-1:0]       count_next;

  // Writes retire producers first; a same-cycle issue is the newer producer and wins.
  always_comb begin
    busy_next = busy;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en && issue_rd != AW'(ZERO_REG)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      count_next = count_next + CW'(busy_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // A write landing this cycle makes the forwarded value current, so hide busy.
  always_comb begin
    rs_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] ra;
      logic          hit;
      ra  = rs_addr[i*AW +: AW];
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
          hit = 1'b1;
        end
      end
      rs_busy[i] = busy[ra] && !((BYPASS != 0) && hit);
    end
  end

endmodule

// File: rtl/registers_unit_mp.sv
// Multi-port architectural register unit: storage with priority write ports,
// zero-latency reads with optional write bypass, and a pending-write scoreboard.
module registers_unit_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd,
  output logic [AW:0]              busy_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Later ports are applied last, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs[AW'(r)] <= (r == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != AW'(ZERO_REG)) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    assign ra = rs_addr[i*AW +: AW];

    always_comb begin
      rd = regs[ra];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
            rd = wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
      if (ra == AW'(ZERO_REG)) begin
        rd = '0;
      end
    end

    assign rs_data[i*DATA_W +: DATA_W] = rd;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rs_addr    (rs_addr),
    .rs_busy    (rs_busy),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_registers_unit_mp.sv
// Bench for registers_unit_mp: a bypassing and a non-bypassing instance share
// stimulus and are compared every cycle against a behavioural register-file model.
module tb_registers_unit_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;

  logic [63:0] rd1, rd0;
  logic [1:0]  rb1, rb0;
  logic [5:0]  bc1, bc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  registers_unit_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd1), .rs_busy(rb1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_count(bc1)
  );

  registers_unit_mp #(.BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd0), .rs_busy(rb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_count(bc0)
  );

  // Behavioural model: architectural state as plain arrays.
  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  bit          model_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] waddr(input int j);
    logic [9:0] v;
    v = wr_addr;
    return v[j*5 +: 5];
  endfunction

  // True if some enabled port writes register a this cycle; returns the winning data.
  function automatic bit write_hit(input logic [4:0] a, output logic [31:0] d);
    d = '0;
    for (int j = 1; j >= 0; j--) begin
      if (wr_en[j] && waddr(j) == a) begin
        d = wr_data[j*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(input int port, input bit byp);
    logic [4:0]  a;
    logic [31:0] d;
    a = rs_addr[port*5 +: 5];
    if (a == 5'd0) return 32'h0;
    if (byp && write_hit(a, d)) return d;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input int port, input bit byp);
    logic [4:0]  a;
    logic [31:0] d;
    a = rs_addr[port*5 +: 5];
    if (byp && write_hit(a, d)) return 1'b0;
    return mbusy[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
      mregs[2] = 32'h0000_0200;
      mbusy = 32'h0;
      model_valid = 1'b1;
    end else begin
      logic [31:0] d;
      logic [31:0] nbusy;
      nbusy = mbusy;
      for (int r = 1; r < 32; r++) begin
        if (write_hit(5'(r), d)) begin
          mregs[r] = d;
          nbusy[r] = 1'b0;
        end
      end
      if (issue_en && issue_rd != 5'd0) nbusy[issue_rd] = 1'b1;
      mbusy = nbusy;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk("byp_rs_data", 64'(rd1[i*32 +: 32]), 64'(exp_data(i, 1'b1)));
        chk("nobyp_rs_data", 64'(rd0[i*32 +: 32]), 64'(exp_data(i, 1'b0)));
        chk("byp_rs_busy", 64'(rb1[i]), 64'(exp_busy(i, 1'b1)));
        chk("nobyp_rs_busy", 64'(rb0[i]), 64'(exp_busy(i, 1'b0)));
      end
      chk("byp_busy_count", 64'(bc1), 64'($countones(mbusy)));
      chk("nobyp_busy_count", 64'(bc0), 64'($countones(mbusy)));
    end
  end

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr  = 10'd0;
    wr_data  = 64'd0;
    issue_en = 1'b0;
    issue_rd = 5'd0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = 10'd0;
    idle();
    next(); next();
    rst = 1'b0;
    rs_addr = {5'd0, 5'd2};
    sample();
    chk("reset_x2", 64'(rd1[31:0]), 64'h200);
    chk("reset_x0", 64'(rd1[63:32]), 64'h0);
    chk("reset_x2_nobyp", 64'(rd0[31:0]), 64'h200);
    chk("reset_busy_count", 64'(bc1), 64'd0);
    chk("reset_rs_busy", 64'(rb1), 64'd0);

    // Both ports write x5: port 1 wins.
    next();
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'hCAFE_BABE, 32'h1111_1111};
    rs_addr = {5'd0, 5'd5};
    sample();
    chk("x5_bypass_same_cycle", 64'(rd1[31:0]), 64'hCAFE_BABE);
    chk("x5_nobyp_same_cycle", 64'(rd0[31:0]), 64'h0);
    next(); idle();
    sample();
    chk("x5_after_write", 64'(rd1[31:0]), 64'hCAFE_BABE);
    chk("x5_after_write_nobyp", 64'(rd0[31:0]), 64'hCAFE_BABE);

    // x7 write observed on read port 1.
    next();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hBAAD_F00D};
    rs_addr = {5'd7, 5'd5};
    sample();
    chk("x7_nobyp_old", 64'(rd0[63:32]), 64'h0);
    chk("x7_byp_new", 64'(rd1[63:32]), 64'hBAAD_F00D);
    next(); idle();
    sample();
    chk("x7_nobyp_next", 64'(rd0[63:32]), 64'hBAAD_F00D);

    // Scoreboard: issue x10 then x11.
    next();
    issue_en = 1'b1; issue_rd = 5'd10; rs_addr = {5'd0, 5'd10};
    sample();
    chk("issue_not_yet_visible", 64'(bc1), 64'd0);
    next();
    issue_rd = 5'd11;
    sample();
    chk("busy_count_1", 64'(bc1), 64'd1);
    chk("x10_busy", 64'(rb1[0]), 64'd1);
    next(); idle();
    sample();
    chk("busy_count_2", 64'(bc1), 64'd2);

    // Writeback of x10 clears busy; bypass masks rs_busy the same cycle.
    next();
    wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h1234_5678, 32'h0};
    sample();
    chk("x10_wb_busy_masked", 64'(rb1[0]), 64'd0);
    chk("x10_wb_data_bypass", 64'(rd1[31:0]), 64'h1234_5678);
    chk("x10_wb_busy_nobyp", 64'(rb0[0]), 64'd1);
    next(); idle();
    sample();
    chk("busy_count_after_wb", 64'(bc1), 64'd1);

    // Issue and write x4 together; also write x3.
    next();
    issue_en = 1'b1; issue_rd = 5'd4;
    wr_en = 2'b11; wr_addr = {5'd3, 5'd4}; wr_data = {32'h3333_3333, 32'hA5A5_A5A5};
    rs_addr = {5'd3, 5'd4};
    next(); idle();
    sample();
    chk("x4_data", 64'(rd1[31:0]), 64'hA5A5_A5A5);
    chk("x4_still_busy", 64'(rb1[0]), 64'd1);
    chk("busy_count_x11_x4", 64'(bc1), 64'd2);
    chk("x3_data", 64'(rd1[63:32]), 64'h3333_3333);

    // x0 ignores issue and write.
    next();
    issue_en = 1'b1; issue_rd = 5'd0;
    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'hDEAD_BEEF, 32'h0};
    rs_addr = {5'd0, 5'd0};
    sample();
    chk("x0_bypass_zero", 64'(rd1[31:0]), 64'h0);
    chk("x0_rs_busy", 64'(rb1), 64'd0);
    next(); idle();
    sample();
    chk("x0_after_write", 64'(rd1[31:0]), 64'h0);
    chk("busy_count_unchanged", 64'(bc1), 64'd2);

    // Reset overrides a same-cycle write and issue.
    next();
    issue_en = 1'b1; issue_rd = 5'd10;
    next(); idle();
    rst = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h7777_7777};
    issue_en = 1'b1; issue_rd = 5'd12;
    rs_addr = {5'd2, 5'd3};
    sample();
    chk("busy_count_before_rst", 64'(bc1), 64'd3);
    next(); idle();
    rst = 1'b0;
    sample();
    chk("rst_x3", 64'(rd1[31:0]), 64'h0);
    chk("rst_x2", 64'(rd1[63:32]), 64'h200);
    chk("rst_busy_count", 64'(bc1), 64'd0);
    chk("rst_rs_busy", 64'(rb1), 64'd0);

    next(); next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
